// File: rtl/crc_stream_engine.sv
// rtl/crc_stream_engine.sv - streaming CRC generator/checker with MSB-first CRC append
//
// Purpose: computes a WIDTH-bit CRC over a stream of DW-bit beats. In generate mode the
// final CRC is emitted on the output stream as WIDTH/DW chunks. In check mode the message
// is expected to carry its own CRC, and the final register is compared against RESIDUE.
//
// Ports:
//   Clk        rising-edge clock
//   R          asynchronous active-low reset
//   start      begins a frame when idle; mode is sampled with it (0=generate, 1=check)
//   in_valid / in_data / in_last / in_ready      message input stream, in_data[DW-1] first
//   out_valid / out_data / out_last / out_ready  CRC append stream, MSB-first chunks
//   crc        final CRC of the last completed frame
//   crc_valid  one-cycle pulse when crc / crc_err are valid
//   crc_err    check-mode mismatch flag
module crc_stream_engine #(
  parameter int unsigned      WIDTH   = 16,
  parameter logic [WIDTH-1:0] POLY    = 16'h1021,
  parameter logic [WIDTH-1:0] INIT    = '0,
  parameter logic [WIDTH-1:0] RESIDUE = '0,
  parameter int unsigned      DW      = 1
) (
  input  logic             Clk,
  input  logic             R,
  input  logic             start,
  input  logic             mode,
  input  logic             in_valid,
  input  logic [DW-1:0]    in_data,
  input  logic             in_last,
  output logic             in_ready,
  output logic             out_valid,
  output logic [DW-1:0]    out_data,
  output logic             out_last,
  input  logic             out_ready,
  output logic [WIDTH-1:0] crc,
  output logic             crc_valid,
  output logic             crc_err
);

  localparam int unsigned NCHUNK = WIDTH / DW;
  // Keep the counter at least one bit wide even when a single chunk covers the CRC.
  localparam int unsigned CW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST_CHUNK = CW'(NCHUNK - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    APPEND = 2'd2,
    DONE   = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] reg_q, reg_d;
  logic [WIDTH-1:0] crc_q, crc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             mode_q, mode_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] reg_step;

  // DW serial LFSR steps unrolled into one cycle, oldest bit (MSB of the beat) first.
  function automatic logic [WIDTH-1:0] crc_update(input logic [WIDTH-1:0] r,
                                                  input logic [DW-1:0]    d);
    logic [WIDTH-1:0] x;
    logic             fb;
    x = r;
    for (int i = DW - 1; i >= 0; i--) begin
      fb = d[i] ^ x[WIDTH-1];
      x  = (x << 1) ^ (fb ? POLY : '0);
    end
    return x;
  endfunction

  always_ff @(posedge Clk or negedge R) begin
    if (!R) begin
      state_q <= IDLE;
      reg_q   <= '0;
      crc_q   <= '0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      reg_q   <= reg_d;
      crc_q   <= crc_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    reg_d    = reg_q;
    crc_d    = crc_q;
    cnt_d    = cnt_q;
    mode_d   = mode_q;
    err_d    = err_q;
    reg_step = crc_update(reg_q, in_data);

    case (state_q)
      IDLE: begin
        if (start) begin
          reg_d   = INIT;
          mode_d  = mode;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (in_valid) begin
          reg_d = reg_step;
          if (in_last) begin
            crc_d = reg_step;
            if (mode_q) begin
              // err is latched on entry to DONE so it stays valid until the next DONE.
              err_d   = (reg_step != RESIDUE);
              state_d = DONE;
            end else begin
              cnt_d   = '0;
              state_d = APPEND;
            end
          end
        end
      end
      APPEND: begin
        // reg_q is consumed as a shift register; its top DW bits are the current chunk.
        if (out_ready) begin
          reg_d = reg_q << DW;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_CHUNK) begin
            err_d   = 1'b0;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign in_ready  = (state_q == RUN);
  assign out_valid = (state_q == APPEND);
  assign out_data  = out_valid ? reg_q[WIDTH-1 -: DW] : '0;
  assign out_last  = out_valid && (cnt_q == LAST_CHUNK);
  assign crc       = crc_q;
  assign crc_valid = (state_q == DONE);
  assign crc_err   = err_q;

endmodule

// File: tb/tb_crc_stream_engine.sv
// tb/tb_crc_stream_engine.sv - scoreboard bench for crc_stream_engine (DW=1 and DW=8)
module tb_crc_stream_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        s8_start, s8_mode, s8_in_valid, s8_in_last, s8_in_ready;
  logic        s8_out_valid, s8_out_last, s8_out_ready, s8_crc_valid, s8_crc_err;
  logic [7:0]  s8_in_data, s8_out_data;
  logic [15:0] s8_crc;

  logic        s1_start, s1_mode, s1_in_valid, s1_in_last, s1_in_ready;
  logic        s1_out_valid, s1_out_last, s1_out_ready, s1_crc_valid, s1_crc_err;
  logic [0:0]  s1_in_data, s1_out_data;
  logic [15:0] s1_crc;

  crc_stream_engine #(.DW(8)) u_dw8 (
    .Clk(clk), .R(rst_n), .start(s8_start), .mode(s8_mode),
    .in_valid(s8_in_valid), .in_data(s8_in_data), .in_last(s8_in_last), .in_ready(s8_in_ready),
    .out_valid(s8_out_valid), .out_data(s8_out_data), .out_last(s8_out_last),
    .out_ready(s8_out_ready), .crc(s8_crc), .crc_valid(s8_crc_valid), .crc_err(s8_crc_err)
  );

  crc_stream_engine #(.DW(1)) u_dw1 (
    .Clk(clk), .R(rst_n), .start(s1_start), .mode(s1_mode),
    .in_valid(s1_in_valid), .in_data(s1_in_data), .in_last(s1_in_last), .in_ready(s1_in_ready),
    .out_valid(s1_out_valid), .out_data(s1_out_data), .out_last(s1_out_last),
    .out_ready(s1_out_ready), .crc(s1_crc), .crc_valid(s1_crc_valid), .crc_err(s1_crc_err)
  );

  typedef struct { logic [7:0] data; logic last; } chunk_t;
  typedef struct { logic [15:0] crc; logic err; logic crc_known; } done_t;

  chunk_t q8_out[$];
  chunk_t q1_out[$];
  done_t  q8_done[$];
  done_t  q1_done[$];

  int checks = 0;
  int errors = 0;

  logic [7:0] msg [9] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event not seen / not expected", name);
  endtask

  // Monitors: pop the scoreboard whenever the DUT presents a transfer.
  chunk_t m8_c, m1_c;
  done_t  m8_d, m1_d;

  always @(negedge clk) begin
    if (rst_n) begin
      if (s8_out_valid && s8_out_ready) begin
        if (q8_out.size() == 0) fail_now("dw8_extra_chunk");
        else begin
          m8_c = q8_out.pop_front();
          chk("dw8_out_data", {24'b0, s8_out_data}, {24'b0, m8_c.data});
          chk("dw8_out_last", {31'b0, s8_out_last}, {31'b0, m8_c.last});
        end
      end
      if (s8_crc_valid) begin
        if (q8_done.size() == 0) fail_now("dw8_extra_crc_valid");
        else begin
          m8_d = q8_done.pop_front();
          if (m8_d.crc_known) chk("dw8_crc", {16'b0, s8_crc}, {16'b0, m8_d.crc});
          chk("dw8_crc_err", {31'b0, s8_crc_err}, {31'b0, m8_d.err});
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (s1_out_valid && s1_out_ready) begin
        if (q1_out.size() == 0) fail_now("dw1_extra_chunk");
        else begin
          m1_c = q1_out.pop_front();
          chk("dw1_out_data", {31'b0, s1_out_data}, {24'b0, m1_c.data});
          chk("dw1_out_last", {31'b0, s1_out_last}, {31'b0, m1_c.last});
        end
      end
      if (s1_crc_valid) begin
        if (q1_done.size() == 0) fail_now("dw1_extra_crc_valid");
        else begin
          m1_d = q1_done.pop_front();
          if (m1_d.crc_known) chk("dw1_crc", {16'b0, s1_crc}, {16'b0, m1_d.crc});
          chk("dw1_crc_err", {31'b0, s1_crc_err}, {31'b0, m1_d.err});
        end
      end
    end
  end

  // ---------------- DW=8 helpers ----------------
  task automatic start8(input logic m);
    s8_start = 1'b1; s8_mode = m;
    @(posedge clk); #1;
    s8_start = 1'b0;
  endtask

  task automatic beat8(input logic [7:0] d, input logic last);
    bit rdy;
    int n;
    rdy = 1'b0; n = 0;
    s8_in_valid = 1'b1; s8_in_data = d; s8_in_last = last;
    while (!rdy && n < 50) begin
      @(negedge clk); rdy = s8_in_ready;
      @(posedge clk); #1; n++;
    end
    if (!rdy) fail_now("dw8_in_ready_timeout");
    s8_in_valid = 1'b0; s8_in_last = 1'b0;
  endtask

  task automatic wait_done8();
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 200 && !seen; n++) begin
      @(negedge clk); seen = s8_crc_valid;
    end
    if (!seen) fail_now("dw8_crc_valid_timeout");
    @(posedge clk); #1;
  endtask

  task automatic push_gen8();
    chunk_t c;
    done_t  d;
    c.data = 8'h31; c.last = 1'b0; q8_out.push_back(c);
    c.data = 8'hC3; c.last = 1'b1; q8_out.push_back(c);
    d.crc = 16'h31C3; d.err = 1'b0; d.crc_known = 1'b1; q8_done.push_back(d);
  endtask

  task automatic check8(input logic flip, input logic exp_err);
    done_t d;
    d.crc = 16'h0000; d.err = exp_err; d.crc_known = !flip;
    q8_done.push_back(d);
    start8(1'b1);
    for (int i = 0; i < 9; i++) beat8(msg[i] ^ ((flip && i == 4) ? 8'h01 : 8'h00), 1'b0);
    beat8(8'h31, 1'b0);
    beat8(8'hC3, 1'b1);
    chk("dw8_check_latency", {31'b0, s8_crc_valid}, 32'd1);
    wait_done8();
  endtask

  // ---------------- DW=1 helpers ----------------
  task automatic beat1(input logic d, input logic last);
    bit rdy;
    int n;
    rdy = 1'b0; n = 0;
    s1_in_valid = 1'b1; s1_in_data = d; s1_in_last = last;
    while (!rdy && n < 50) begin
      @(negedge clk); rdy = s1_in_ready;
      @(posedge clk); #1; n++;
    end
    if (!rdy) fail_now("dw1_in_ready_timeout");
    s1_in_valid = 1'b0; s1_in_last = 1'b0;
  endtask

  task automatic wait_done1();
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 200 && !seen; n++) begin
      @(negedge clk); seen = s1_crc_valid;
    end
    if (!seen) fail_now("dw1_crc_valid_timeout");
    @(posedge clk); #1;
  endtask

  task automatic push_gen1(input int nchunks, input logic with_done);
    logic [15:0] v;
    chunk_t c;
    done_t  d;
    v = 16'h1021;
    for (int i = 15; i > 15 - nchunks; i--) begin
      c.data = {7'b0, v[i]}; c.last = (i == 0); q1_out.push_back(c);
    end
    if (with_done) begin
      d.crc = 16'h1021; d.err = 1'b0; d.crc_known = 1'b1; q1_done.push_back(d);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    s8_start = 0; s8_mode = 0; s8_in_valid = 0; s8_in_data = '0; s8_in_last = 0; s8_out_ready = 1;
    s1_start = 0; s1_mode = 0; s1_in_valid = 0; s1_in_data = '0; s1_in_last = 0; s1_out_ready = 1;
    #12;
    chk("rst_dw8_in_ready",  {31'b0, s8_in_ready},  32'd0);
    chk("rst_dw8_out_valid", {31'b0, s8_out_valid}, 32'd0);
    chk("rst_dw8_crc",       {16'b0, s8_crc},       32'd0);
    chk("rst_dw8_crc_valid", {31'b0, s8_crc_valid}, 32'd0);
    chk("rst_dw1_out_data",  {31'b0, s1_out_data},  32'd0);
    chk("rst_dw1_crc_err",   {31'b0, s1_crc_err},   32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_dw8_in_ready", {31'b0, s8_in_ready}, 32'd0);

    // DW=1 generate, single-beat frame of a '1' bit -> CRC 0x1021 emitted MSB-first
    push_gen1(16, 1'b1);
    s1_start = 1'b1; s1_mode = 1'b0;
    @(posedge clk); #1;
    s1_start = 1'b0;
    beat1(1'b1, 1'b1);
    chk("dw1_gen_latency", {31'b0, s1_out_valid}, 32'd1);
    wait_done1();

    // DW=8 generate over "123456789"
    push_gen8();
    start8(1'b0);
    for (int i = 0; i < 9; i++) beat8(msg[i], i == 8);
    chk("dw8_gen_latency", {31'b0, s8_out_valid}, 32'd1);
    wait_done8();
    repeat (3) @(posedge clk);
    #1;
    chk("dw8_crc_hold",     {16'b0, s8_crc},      32'h31C3);
    chk("dw8_crc_err_hold", {31'b0, s8_crc_err},  32'd0);

    // DW=8 check mode: good message, then one flipped data bit
    check8(1'b0, 1'b0);
    check8(1'b1, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    chk("dw8_err_hold", {31'b0, s8_crc_err}, 32'd1);

    // DW=8 generate with the append stream stalled for 5 cycles
    push_gen8();
    s8_out_ready = 1'b0;
    start8(1'b0);
    for (int i = 0; i < 9; i++) beat8(msg[i], i == 8);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_out_valid", {31'b0, s8_out_valid}, 32'd1);
      chk("stall_out_data",  {24'b0, s8_out_data},  32'h31);
      chk("stall_out_last",  {31'b0, s8_out_last},  32'd0);
    end
    @(posedge clk); #1;
    s8_out_ready = 1'b1;
    wait_done8();

    // DW=8 generate with in_valid gaps and a stray start pulse during RUN
    push_gen8();
    start8(1'b0);
    for (int i = 0; i < 9; i++) begin
      beat8(msg[i], i == 8);
      if (i < 8) begin
        for (int g = 0; g < (i % 3) + 1; g++) begin
          s8_start = (i == 3); s8_mode = (i == 3);
          @(posedge clk); #1;
          s8_start = 1'b0; s8_mode = 1'b0;
        end
        if (i == 5) chk("dw8_crc_hold_run", {16'b0, s8_crc}, 32'h31C3);
      end
    end
    wait_done8();

    // DW=1 generate aborted by reset during the 3rd append chunk
    push_gen1(2, 1'b0);
    s1_out_ready = 1'b0;
    s1_start = 1'b1; s1_mode = 1'b0;
    @(posedge clk); #1;
    s1_start = 1'b0;
    beat1(1'b1, 1'b1);
    s1_out_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    s1_out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", {31'b0, s1_out_valid}, 32'd0);
    chk("abort_out_data",  {31'b0, s1_out_data},  32'd0);
    chk("abort_out_last",  {31'b0, s1_out_last},  32'd0);
    chk("abort_in_ready",  {31'b0, s1_in_ready},  32'd0);
    chk("abort_crc",       {16'b0, s1_crc},       32'd0);
    chk("abort_crc_valid", {31'b0, s1_crc_valid}, 32'd0);
    chk("abort_crc_err",   {31'b0, s1_crc_err},   32'd0);
    chk("abort_dw8_crc",   {16'b0, s8_crc},       32'd0);
    @(posedge clk);
    @(posedge clk);
    #3;
    s1_out_ready = 1'b1;
    push_gen1(16, 1'b1);
    s1_start = 1'b1; s1_mode = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    s1_start = 1'b0;
    chk("start_after_reset", {31'b0, s1_in_ready}, 32'd1);
    beat1(1'b1, 1'b1);
    wait_done1();

    // DW=8 still correct after reset
    check8(1'b0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    chk("q8_out_empty",  q8_out.size(),  32'd0);
    chk("q8_done_empty", q8_done.size(), 32'd0);
    chk("q1_out_empty",  q1_out.size(),  32'd0);
    chk("q1_done_empty", q1_done.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/crc_stream_engine.md
CRC_STREAM_ENGINE -- requirements
Module: crc_stream_engine

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning CRC register width in bits.
REQ-002 The block SHALL have parameter POLY, default 16'h1021, meaning the generator polynomial with the implicit x^WIDTH term omitted.
REQ-003 The block SHALL have parameter INIT, default 0, meaning the CRC register value loaded on start.
REQ-004 The block SHALL have parameter RESIDUE, default 0, meaning the expected register value after a valid message plus its appended CRC.
REQ-005 The block SHALL have parameter DW, default 1, meaning data bits consumed or emitted per handshake; WIDTH % DW == 0 and DW <= WIDTH are required.
REQ-006 The block SHALL have the following port: Clk  in  1  rising-edge clock, the only clock.
REQ-007 The block SHALL have the following port: R  in  1  asynchronous active-low reset (R=0 resets).
REQ-008 The block SHALL have the following port: start  in  1  begins a frame when in IDLE.
REQ-009 The block SHALL have the following port: mode  in  1  sampled with start; 0=generate, 1=check.
REQ-010 The block SHALL have the following port: in_valid  in  1  in_data is valid.
REQ-011 The block SHALL have the following port: in_data  in  DW  message bits, in_data[DW-1] first in time.
REQ-012 The block SHALL have the following port: in_last  in  1  marks the final beat of the message.
REQ-013 The block SHALL have the following port: in_ready  out  1  block accepts in_data.
REQ-014 The block SHALL have the following port: out_valid  out  1  out_data carries a CRC chunk.
REQ-015 The block SHALL have the following port: out_data  out  DW  CRC chunk, MSB-first.
REQ-016 The block SHALL have the following port: out_last  out  1  final CRC chunk.
REQ-017 The block SHALL have the following port: out_ready  in  1  downstream accepts out_data.
REQ-018 The block SHALL have the following port: crc  out  WIDTH  final CRC of the last frame.
REQ-019 The block SHALL have the following port: crc_valid  out  1  one-cycle pulse, crc and crc_err are valid.
REQ-020 The block SHALL have the following port: crc_err  out  1  check-mode mismatch flag.

Function
REQ-021 The block SHALL implement FSM states IDLE, RUN, APPEND and DONE; no other state is reachable.
REQ-022 In IDLE, start=1 SHALL load the register with INIT and latch mode, then enter RUN next cycle; in_ready=0 and out_valid=0 in IDLE.
REQ-023 The block SHALL ignore start in every state except IDLE.
REQ-024 In RUN, in_ready SHALL be 1 and a beat SHALL be accepted on in_valid & in_ready; with no accepted beat the register holds.
REQ-025 Per accepted beat, the block SHALL apply DW serial steps in one cycle, bit in_data[DW-1] first; each step is fb = d ^ reg[WIDTH-1]; reg = (reg << 1) ^ (fb ? POLY : 0), truncated to WIDTH bits.
REQ-026 On the accepted beat with in_last=1, the block SHALL copy the updated register into crc and go to APPEND in generate mode or DONE in check mode.
REQ-027 In APPEND, out_valid SHALL be 1, in_ready 0, and out_data = reg[WIDTH-1 -: DW].
REQ-028 In APPEND, on out_ready, reg SHALL shift left by DW and a chunk counter increment; out_last=1 on chunk WIDTH/DW-1; after that chunk is accepted the FSM enters DONE.
REQ-029 With out_ready=0, out_data, out_last and out_valid SHALL hold stable.
REQ-030 DONE SHALL last exactly one cycle with crc_valid=1, then return to IDLE.
REQ-031 In DONE, crc_err SHALL be 1 if and only if mode=check and crc != RESIDUE; crc_err is 0 in generate mode.
REQ-032 crc and crc_err SHALL hold their values until the next frame's DONE or reset.
REQ-033 A single-beat frame (in_last on the first beat) SHALL be legal.
REQ-034 Latency SHALL be 1 cycle from the last accepted beat to DONE in check mode, and 1 cycle from the last accepted beat to the first out_valid in generate mode.

Reset
REQ-035 When R=0, regardless of Clk, the block SHALL force state=IDLE, the register=0, crc=0, the counter=0, and in_ready, out_valid, out_last, out_data, crc_valid and crc_err all to 0.
REQ-036 Reset asserted mid-frame (RUN or APPEND) SHALL abort the frame with no crc_valid pulse; the block SHALL accept start on the first clock edge after R rises.

Verification
REQ-037 Scenario (DW=1, defaults): start in generate mode, a single beat in_data=1 with in_last=1 -> the bench SHALL see crc=16'h1021, then 16 out_valid beats emitting 0001000000100001, out_last on the 16th.
REQ-038 Scenario (DW=8): generate over ASCII "123456789" -> the bench SHALL see crc=16'h31C3, out_data 8'h31 then 8'hC3, and one crc_valid pulse with crc_err=0.
REQ-039 Scenario (DW=8): check over "123456789",8'h31,8'hC3 -> the bench SHALL see crc_valid with crc=0 and crc_err=0; flipping one data bit SHALL give crc_err=1.
REQ-040 Scenario: hold out_ready=0 for 5 cycles during APPEND -> out_data SHALL stay stable, with no lost or duplicated chunk.
REQ-041 Scenario: assert R=0 during the 3rd APPEND beat -> all outputs SHALL go to 0 immediately with no crc_valid, and the next frame computes correctly.
REQ-042 Scenario: pulse start during RUN and insert in_valid gaps -> the bench SHALL see no restart, and the result SHALL equal the gap-free result.
